exec_sequencer: RTL and testbench
=================================

EXEC_SEQUENCER -- requirements
Module: exec_sequencer

Interface
REQ-001 SHALL have parameter PC_W, default 26, program-counter width.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 16, maximum memory-ack wait in cycles (used only with SEQ_TIMEOUT_EN).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port run  input  1  enables instruction sequencing.
REQ-006 SHALL have port imem_ack  input  1  instruction memory data valid.
REQ-007 SHALL have port imem_rdata  input  32  fetched instruction.
REQ-008 SHALL have ports load_pc (1), load_pc_val (PC_W), reg_write_enable (1), mem_rd (1) and mem_wr (1), all inputs, decoded control from the decoder.
REQ-009 SHALL have port dmem_ack  input  1  data memory transfer complete.
REQ-010 SHALL have port imem_req  output  1  instruction fetch request.
REQ-011 SHALL have port pc  output  PC_W  current instruction address.
REQ-012 SHALL have port instr  output  32  instruction register feeding the decoder.
REQ-013 SHALL have ports dmem_req (1) and dmem_we (1), outputs, data memory request and write qualifier.
REQ-014 SHALL have port reg_we  output  1  one-cycle register-file write strobe.
REQ-015 SHALL have port status_we  output  1  one-cycle status-register update strobe.
REQ-016 SHALL have port fault  output  1  sticky timeout flag.

Function
REQ-017 SHALL implement states IDLE, FETCH, DECODE, EXEC, MEM, WB and FAULT.
REQ-018 SHALL transition IDLE->FETCH when run=1; otherwise SHALL hold IDLE.
REQ-019 SHALL assert imem_req combinationally only in FETCH, and SHALL load instr from imem_rdata and move to DECODE in the cycle imem_ack=1; ack in the first FETCH cycle counts.
REQ-020 SHALL spend exactly one cycle in DECODE, then go to EXEC.
REQ-021 SHALL spend exactly one cycle in EXEC, pulsing status_we when instr[31:26]=6'b001010 (CMP).
REQ-022 SHALL go EXEC->MEM if mem_rd|mem_wr, else EXEC->WB.
REQ-023 SHALL hold dmem_req=1 throughout MEM, with dmem_we=mem_wr, and SHALL go to WB in the cycle dmem_ack=1.
REQ-024 SHALL pulse reg_we for one cycle in WB when reg_write_enable=1.
REQ-025 SHALL, on WB exit, set pc to load_pc_val when load_pc=1, else pc+1 modulo 2^PC_W (all-ones wraps to 0).
REQ-026 SHALL go WB->FETCH if run=1, else WB->IDLE; deasserting run mid-instruction SHALL NOT abort it.
REQ-027 SHALL give latency FETCH-entry to next FETCH-entry of 4 cycles for non-memory instructions with same-cycle ack, plus 1 + ack-wait cycles for memory instructions.
REQ-028 SHALL ignore imem_ack outside FETCH and dmem_ack outside MEM.

Reset
REQ-029 SHALL, on rst=1 at any time, immediately force state IDLE, pc=0, instr=0, and imem_req, dmem_req, dmem_we, reg_we, status_we and fault all 0.
REQ-030 SHALL abandon any in-flight request on reset, and SHALL resume sequencing from pc=0 on the first clk edge after rst falls.

Configuration
REQ-031 SHALL use macro SEQ_TIMEOUT_EN: when defined, TIMEOUT_CYCLES consecutive cycles in FETCH or MEM without ack SHALL move the block to FAULT, set fault=1 and drop all requests; FAULT SHALL be left only by reset.
REQ-032 SHALL, without SEQ_TIMEOUT_EN, wait indefinitely for ack, never enter FAULT, and tie fault to 0.

Structure
REQ-033 SHALL take the state enumeration, opcode constants (CMP, LOD, STR) and the PC_W default from the shared package microcpu_pkg.
REQ-034 SHALL place the ack-wait counter in sub-module seq_timeout_counter, instantiated only under SEQ_TIMEOUT_EN.

Verification
REQ-035 SHALL verify ADD with imem_ack on the first FETCH cycle and reg_write_enable=1: reg_we pulses once, pc 0->1, next FETCH 4 cycles later.
REQ-036 SHALL verify LOD with dmem_ack delayed 3 cycles: dmem_req high 4 cycles with dmem_we=0, then a reg_we pulse, pc+1.
REQ-037 SHALL verify JMP with load_pc=1 and load_pc_val=26'h0000040: pc=0x40 after WB and no reg_we.
REQ-038 SHALL verify pc=2^26-1 with a non-branch instruction: pc wraps to 0.
REQ-039 SHALL verify rst asserted during MEM with dmem_req=1: all outputs are 0 in the same cycle, and FETCH starts at pc=0 after release.
REQ-040 SHALL verify, with SEQ_TIMEOUT_EN and imem_ack held 0: after 16 FETCH cycles fault=1 and imem_req=0, and fault stays 1 until rst.

Source files
------------

// File: rtl/microcpu_pkg.sv
// Shared definitions for the micro-CPU: sequencer state set, opcode constants
// and the default program-counter width.
package microcpu_pkg;

    localparam int unsigned PC_W_DEFAULT = 26;

    localparam logic [5:0] OP_CMP = 6'b001010;
    localparam logic [5:0] OP_LOD = 6'b100011;
    localparam logic [5:0] OP_STR = 6'b101011;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        EXEC,
        MEM,
        WB,
        FAULT
    } seq_state_e;

    function automatic logic is_cmp(input logic [31:0] ins);
        return ins[31:26] == OP_CMP;
    endfunction

endpackage

// File: rtl/seq_timeout_counter.sv
// Counts consecutive cycles spent waiting for a memory ack; flags expiry on
// the TIMEOUT_CYCLES-th unacknowledged cycle.
module seq_timeout_counter #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic waiting,
    input  logic ack,
    output logic expired
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (waiting && !ack) begin
            count <= count + 1'b1;
        end else begin
            count <= '0;
        end
    end

    // Count holds the number of earlier idle wait cycles, so the current one is the last allowed.
    assign expired = waiting && !ack && (count == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/exec_sequencer.sv
// Instruction sequencer: FETCH/DECODE/EXEC/MEM/WB control with PC and IR.
// Optional ack-wait timeout into a sticky FAULT state under `SEQ_TIMEOUT_EN.
module exec_sequencer
    import microcpu_pkg::*;
#(
    parameter int unsigned PC_W           = PC_W_DEFAULT,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            run,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    input  logic            load_pc,
    input  logic [PC_W-1:0] load_pc_val,
    input  logic            reg_write_enable,
    input  logic            mem_rd,
    input  logic            mem_wr,
    input  logic            dmem_ack,
    output logic            imem_req,
    output logic [PC_W-1:0] pc,
    output logic [31:0]     instr,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic            reg_we,
    output logic            status_we,
    output logic            fault
);

    seq_state_e state, state_next;
    logic       wait_expired;

`ifdef SEQ_TIMEOUT_EN
    logic waiting;
    logic wait_ack;

    assign waiting  = (state == FETCH) || (state == MEM);
    assign wait_ack = ((state == FETCH) && imem_ack) || ((state == MEM) && dmem_ack);

    seq_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .waiting(waiting),
        .ack    (wait_ack),
        .expired(wait_expired)
    );
`else
    assign wait_expired = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        imem_req   = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        reg_we     = 1'b0;
        status_we  = 1'b0;
        fault      = 1'b0;
        case (state)
            IDLE: begin
                if (run) state_next = FETCH;
            end
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    state_next = DECODE;
                end else if (wait_expired) begin
                    state_next = FAULT;
                end
            end
            DECODE: begin
                state_next = EXEC;
            end
            EXEC: begin
                status_we  = is_cmp(instr);
                state_next = (mem_rd || mem_wr) ? MEM : WB;
            end
            MEM: begin
                dmem_req = 1'b1;
                dmem_we  = mem_wr;
                if (dmem_ack) begin
                    state_next = WB;
                end else if (wait_expired) begin
                    state_next = FAULT;
                end
            end
            WB: begin
                reg_we     = reg_write_enable;
                state_next = run ? FETCH : IDLE;
            end
            FAULT: begin
`ifdef SEQ_TIMEOUT_EN
                fault = 1'b1;
`endif
                state_next = FAULT;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // PC advances on the single WB cycle; plain increment wraps all-ones to zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc    <= '0;
            instr <= '0;
        end else begin
            if ((state == FETCH) && imem_ack) begin
                instr <= imem_rdata;
            end
            if (state == WB) begin
                pc <= load_pc ? load_pc_val : pc + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_exec_sequencer.sv
// Scoreboard bench for exec_sequencer: a driver plays memory/decoder and queues
// per-instruction expectations; a monitor checks them at each FETCH entry.
module tb_exec_sequencer;

    localparam int unsigned PCW = 26;
    localparam int unsigned TO  = 16;

    localparam logic [5:0] T_ADD = 6'b000000;
    localparam logic [5:0] T_JMP = 6'b000010;
    localparam logic [5:0] T_CMP = 6'b001010;
    localparam logic [5:0] T_LOD = 6'b100011;
    localparam logic [5:0] T_STR = 6'b101011;

    logic           clk;
    logic           rst;
    logic           run;
    logic           imem_ack;
    logic [31:0]    imem_rdata;
    logic           load_pc;
    logic [PCW-1:0] load_pc_val;
    logic           reg_write_enable;
    logic           mem_rd;
    logic           mem_wr;
    logic           dmem_ack;
    logic           imem_req;
    logic [PCW-1:0] pc;
    logic [31:0]    instr;
    logic           dmem_req;
    logic           dmem_we;
    logic           reg_we;
    logic           status_we;
    logic           fault;

    exec_sequencer #(
        .PC_W          (PCW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .run             (run),
        .imem_ack        (imem_ack),
        .imem_rdata      (imem_rdata),
        .load_pc         (load_pc),
        .load_pc_val     (load_pc_val),
        .reg_write_enable(reg_write_enable),
        .mem_rd          (mem_rd),
        .mem_wr          (mem_wr),
        .dmem_ack        (dmem_ack),
        .imem_req        (imem_req),
        .pc              (pc),
        .instr           (instr),
        .dmem_req        (dmem_req),
        .dmem_we         (dmem_we),
        .reg_we          (reg_we),
        .status_we       (status_we),
        .fault           (fault)
    );

    typedef struct {
        logic [31:0]    instr;
        int             rwe;
        int             st;
        int             dm;
        int             dmwe;
        int             lat;
        bit             lat_chk;
        logic [PCW-1:0] next_pc;
    } exp_t;

    exp_t           sb[$];
    int             checks   = 0;
    int             failures = 0;
    logic [PCW-1:0] model_pc;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // One complete instruction as seen by memory and decoder; starts at a non-FETCH negedge.
    task automatic do_instr(input logic [5:0] op, input int d_i, input int d_m, input bit rwe,
                            input bit ld, input logic [PCW-1:0] lval, input bit drop);
        exp_t e;
        int   w;
        bit   mwr;
        bit   mem;
        mwr = (op == T_STR);
        mem = (op == T_LOD) || mwr;
        w = 0;
        while (!imem_req && w < 64) begin
            @(negedge clk);
            w++;
        end
        if (!imem_req) begin
            chk("fetch_wait", 64'd0, 64'd1);
            return;
        end
        repeat (d_i) @(negedge clk);
        imem_ack         = 1'b1;
        imem_rdata       = {op, 26'($urandom)};
        load_pc          = ld;
        load_pc_val      = lval;
        reg_write_enable = rwe;
        mem_rd           = (op == T_LOD);
        mem_wr           = mwr;
        e.instr   = imem_rdata;
        e.rwe     = rwe ? 1 : 0;
        e.st      = (op == T_CMP) ? 1 : 0;
        e.dm      = mem ? d_m + 1 : 0;
        e.dmwe    = mwr ? e.dm : 0;
        e.lat     = d_i + 4 + e.dm;
        e.lat_chk = !drop;
        e.next_pc = ld ? lval : PCW'((64'(model_pc) + 64'd1) % (64'd1 << PCW));
        sb.push_back(e);
        model_pc = e.next_pc;
        @(negedge clk);
        imem_ack   = 1'($urandom);
        dmem_ack   = 1'($urandom);
        imem_rdata = $urandom;
        if (drop) run = 1'b0;
        @(negedge clk);
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        if (mem) begin
            @(negedge clk);
            w = 0;
            while (!dmem_req && w < 64) begin
                @(negedge clk);
                w++;
            end
            if (!dmem_req) begin
                chk("dmem_wait", 64'd0, 64'd1);
                return;
            end
            repeat (d_m) @(negedge clk);
            dmem_ack = 1'b1;
            @(negedge clk);
            dmem_ack = 1'b0;
        end else begin
            @(negedge clk);
        end
        if (drop) begin
            repeat (2) @(negedge clk);
            chk("idle_hold_imem_req", 64'(imem_req), 64'd0);
            run = 1'b1;
        end
    endtask

    task automatic random_instr();
        logic [5:0] op;
        bit         ld;
        case ($urandom_range(0, 5))
            0:       op = T_ADD;
            1:       op = T_CMP;
            2:       op = T_LOD;
            3:       op = T_STR;
            4:       op = T_JMP;
            default: op = 6'($urandom);
        endcase
        ld = (op == T_JMP) || ($urandom_range(0, 7) == 0);
        do_instr(op, int'($urandom_range(0, 3)), int'($urandom_range(0, 4)), 1'($urandom),
                 ld, PCW'($urandom), $urandom_range(0, 7) == 0);
    endtask

    initial begin : monitor
        int          cyc;
        int          rwe_c;
        int          st_c;
        int          dm_c;
        int          dmwe_c;
        bit          first;
        logic        prev_req;
        logic [31:0] last_instr;
        exp_t        e;
        cyc = 0; rwe_c = 0; st_c = 0; dm_c = 0; dmwe_c = 0;
        first = 1'b1; prev_req = 1'b0; last_instr = '0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                first = 1'b1;
                cyc = 0; rwe_c = 0; st_c = 0; dm_c = 0; dmwe_c = 0;
                prev_req = 1'b0;
            end else begin
                cyc++;
                if (imem_req && !prev_req) begin
                    if (first) begin
                        chk("first_fetch_pc", 64'(pc), 64'd0);
                        first = 1'b0;
                    end else if (sb.size() == 0) begin
                        chk("sb_underflow", 64'd0, 64'd1);
                    end else begin
                        e = sb.pop_front();
                        if (e.lat_chk) chk("fetch_to_fetch_latency", 64'(cyc), 64'(e.lat));
                        chk("reg_we_pulses", 64'(rwe_c), 64'(e.rwe));
                        chk("status_we_pulses", 64'(st_c), 64'(e.st));
                        chk("dmem_req_cycles", 64'(dm_c), 64'(e.dm));
                        chk("dmem_we_cycles", 64'(dmwe_c), 64'(e.dmwe));
                        chk("instr_reg", 64'(last_instr), 64'(e.instr));
                        chk("next_pc", 64'(pc), 64'(e.next_pc));
                    end
                    cyc = 0; rwe_c = 0; st_c = 0; dm_c = 0; dmwe_c = 0;
                end
                if (reg_we) rwe_c++;
                if (status_we) st_c++;
                if (dmem_req) dm_c++;
                if (dmem_we) dmwe_c++;
                if (!imem_req) last_instr = instr;
                prev_req = imem_req;
            end
        end
    end

    initial begin : driver
        int cnt;
        int w;
        rst = 1'b1; run = 1'b0; imem_ack = 1'b0; imem_rdata = '0; load_pc = 1'b0;
        load_pc_val = '0; reg_write_enable = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0; dmem_ack = 1'b0;
        model_pc = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_imem_req", 64'(imem_req), 64'd0);
        chk("reset_pc", 64'(pc), 64'd0);
        chk("reset_instr", 64'(instr), 64'd0);
        chk("reset_fault", 64'(fault), 64'd0);
        rst = 1'b0;
        run = 1'b1;

        do_instr(T_ADD, 0, 0, 1'b1, 1'b0, '0, 1'b0);
        do_instr(T_LOD, 0, 3, 1'b1, 1'b0, '0, 1'b0);
        do_instr(T_JMP, 1, 0, 1'b0, 1'b1, 26'h0000040, 1'b0);
        do_instr(T_JMP, 0, 0, 1'b0, 1'b1, '1, 1'b0);
        do_instr(T_ADD, 2, 0, 1'b1, 1'b0, '0, 1'b0);
        do_instr(T_CMP, 0, 0, 1'b1, 1'b0, '0, 1'b0);
        do_instr(T_STR, 0, 1, 1'b0, 1'b0, '0, 1'b0);
        do_instr(T_ADD, 1, 0, 1'b1, 1'b0, '0, 1'b1);
        for (int i = 0; i < 40; i++) random_instr();
        repeat (3) @(negedge clk);
        chk("sb_drained", 64'(sb.size()), 64'd0);

        // Reset while a store holds dmem_req in MEM.
        w = 0;
        while (!imem_req && w < 64) begin
            @(negedge clk);
            w++;
        end
        imem_ack = 1'b1; imem_rdata = {T_STR, 26'h155AA}; mem_rd = 1'b0; mem_wr = 1'b1;
        reg_write_enable = 1'b1; load_pc = 1'b0;
        @(negedge clk);
        imem_ack = 1'b0;
        repeat (2) @(negedge clk);
        chk("pre_reset_dmem_req", 64'(dmem_req), 64'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_imem_req", 64'(imem_req), 64'd0);
        chk("rst_dmem_req", 64'(dmem_req), 64'd0);
        chk("rst_dmem_we", 64'(dmem_we), 64'd0);
        chk("rst_reg_we", 64'(reg_we), 64'd0);
        chk("rst_status_we", 64'(status_we), 64'd0);
        chk("rst_fault", 64'(fault), 64'd0);
        chk("rst_pc", 64'(pc), 64'd0);
        chk("rst_instr", 64'(instr), 64'd0);
        sb.delete();
        model_pc = '0;
        mem_wr = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_reset_fetch", 64'(imem_req), 64'd1);
        chk("post_reset_pc", 64'(pc), 64'd0);
        for (int i = 0; i < 6; i++) random_instr();
        repeat (3) @(negedge clk);
        chk("sb_drained_after_reset", 64'(sb.size()), 64'd0);

        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        cnt = 0;
        w = 0;
        @(negedge clk);
`ifdef SEQ_TIMEOUT_EN
        while (imem_req && w < 100) begin
            cnt++;
            w++;
            @(negedge clk);
        end
        chk("timeout_fetch_cycles", 64'(cnt), 64'(TO));
        chk("timeout_fault", 64'(fault), 64'd1);
        chk("timeout_imem_req", 64'(imem_req), 64'd0);
        imem_ack = 1'b1;
        repeat (10) @(negedge clk);
        chk("fault_sticky", 64'(fault), 64'd1);
        chk("fault_no_req", 64'(imem_req), 64'd0);
        imem_ack = 1'b0;
        rst = 1'b1;
        #1;
        chk("fault_cleared_by_rst", 64'(fault), 64'd0);
`else
        while (w < 40) begin
            if (imem_req && !fault) cnt++;
            w++;
            @(negedge clk);
        end
        chk("no_timeout_wait_cycles", 64'(cnt), 64'd40);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule
